m_divide: RTL and testbench

Iterative 32-bit integer divider for the RV32 execute stage's multi-cycle mul/div unit; it is the division counterpart of the multiplier. It accepts a start request with two operands and a signedness flag, runs a radix-2 restoring division over 32 iterations, and returns quotient and remainder with the same begin/working/end handshake the multiplier uses. Results follow RISC-V M semantics (DIV/DIVU/REM/REMU), including the divide-by-zero and signed-overflow cases.

---
 rtl/m_muldiv_defs.sv | 24 ++
 rtl/m_adder.sv | 19 +
 rtl/m_divide.sv | 123 ++++++++++++
 tb/tb_m_divide.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/m_muldiv_defs.sv
// Shared definitions for the multi-cycle mul/div unit.
//   divState_t   : divider FSM state encoding (2-bit)
//   DIV_ITER     : number of restoring-division iterations
//   DIV0_QUOT    : quotient returned for a divide by zero
//   INT_MIN      : most negative 32-bit value (signed-overflow dividend)
//   absVal()     : magnitude of an operand, negated only for signed negatives
package m_muldiv_defs;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } divState_t;

  localparam int unsigned DIV_ITER  = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  function automatic logic [31:0] absVal(input logic [31:0] x, input logic isSigned);
    return (isSigned && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/m_adder.sv
// Generic ripple adder shared by the mul/div datapaths.
//   i_operand1 : first addend (WIDTH bits)
//   i_operand2 : second addend (WIDTH bits)
//   i_cIn_1    : carry in
//   o_sum      : WIDTH-bit sum (carry out discarded; callers widen if needed)
module m_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_operand1,
  input  logic [WIDTH-1:0] i_operand2,
  input  logic             i_cIn_1,
  output logic [WIDTH-1:0] o_sum
);

  always_comb begin
    o_sum = i_operand1 + i_operand2 + {{(WIDTH-1){1'b0}}, i_cIn_1};
  end

endmodule

// File: rtl/m_divide.sv
// Iterative radix-2 restoring divider, RISC-V M semantics (DIV/DIVU/REM/REMU).
//   clk, rst           : clock, synchronous active-high reset
//   i_divBegin_1       : start request, sampled only in IDLE
//   i_divOperand1_32   : dividend
//   i_divOperand2_32   : divisor
//   i_divSigned_1      : 1 = signed operation
//   o_quotient_32      : quotient, written in FIX, held until overwritten
//   o_remainder_32     : remainder, written with the quotient
//   o_divWorking_1     : high in every non-IDLE state
//   o_divEnd_1         : one-cycle pulse in DONE
module m_divide
  import m_muldiv_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_divBegin_1,
  input  logic [31:0] i_divOperand1_32,
  input  logic [31:0] i_divOperand2_32,
  input  logic        i_divSigned_1,
  output logic [31:0] o_quotient_32,
  output logic [31:0] o_remainder_32,
  output logic        o_divWorking_1,
  output logic        o_divEnd_1
);

  divState_t   state, stateNext;
  logic [4:0]  counter;
  logic [31:0] remReg;
  logic [31:0] quoReg;
  logic [31:0] divisorReg;
  logic        negQ, negR, specialCase;

  logic [31:0] magA, magB;
  logic        isDiv0, isOverflow, accept;
  logic [32:0] shifted, trialSum;
  logic        geFlag;

  assign accept     = (state == DIV_IDLE) && i_divBegin_1;
  assign magA       = absVal(i_divOperand1_32, i_divSigned_1);
  assign magB       = absVal(i_divOperand2_32, i_divSigned_1);
  assign isDiv0     = (i_divOperand2_32 == '0);
  assign isOverflow = i_divSigned_1 && (i_divOperand1_32 == INT_MIN) &&
                      (i_divOperand2_32 == '1);

  // The partial remainder is always below the divisor after a restore, so
  // only its low 32 bits are stored; the 33-bit value exists just after the shift.
  assign shifted = {remReg, quoReg[31]};

  m_adder #(.WIDTH(33)) trialAdder (
    .i_operand1 (shifted),
    .i_operand2 (~{1'b0, divisorReg}),
    .i_cIn_1    (1'b1),
    .o_sum      (trialSum)
  );

  assign geFlag = ~trialSum[32];

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      DIV_IDLE: if (i_divBegin_1) stateNext = (isDiv0 || isOverflow) ? DIV_FIX : DIV_CALC;
      DIV_CALC: if (counter == 5'(DIV_ITER - 1)) stateNext = DIV_FIX;
      DIV_FIX:  stateNext = DIV_DONE;
      DIV_DONE: stateNext = DIV_IDLE;
      default:  stateNext = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter        <= '0;
      remReg         <= '0;
      quoReg         <= '0;
      divisorReg     <= '0;
      negQ           <= 1'b0;
      negR           <= 1'b0;
      specialCase    <= 1'b0;
      o_quotient_32  <= '0;
      o_remainder_32 <= '0;
    end else begin
      if (accept) begin
        divisorReg <= magB;
        negQ       <= i_divSigned_1 & (i_divOperand1_32[31] ^ i_divOperand2_32[31]);
        negR       <= i_divSigned_1 & i_divOperand1_32[31];
        counter    <= '0;
        if (isDiv0) begin
          specialCase <= 1'b1;
          quoReg      <= DIV0_QUOT;
          remReg      <= i_divOperand1_32;
        end else if (isOverflow) begin
          specialCase <= 1'b1;
          quoReg      <= INT_MIN;
          remReg      <= '0;
        end else begin
          specialCase <= 1'b0;
          quoReg      <= magA;
          remReg      <= '0;
        end
      end else if (state == DIV_CALC) begin
        remReg  <= geFlag ? trialSum[31:0] : shifted[31:0];
        quoReg  <= {quoReg[30:0], geFlag};
        counter <= counter + 5'd1;
      end else if (state == DIV_FIX) begin
        if (specialCase) begin
          o_quotient_32  <= quoReg;
          o_remainder_32 <= remReg;
        end else begin
          o_quotient_32  <= negQ ? (~quoReg + 32'd1) : quoReg;
          o_remainder_32 <= negR ? (~remReg + 32'd1) : remReg;
        end
      end
    end
  end

  assign o_divWorking_1 = (state != DIV_IDLE);
  assign o_divEnd_1     = (state == DIV_DONE);

endmodule

// File: tb/tb_m_divide.sv
module tb_m_divide;

  logic        clk;
  logic        rst;
  logic        divBegin;
  logic [31:0] opA, opB;
  logic        sgn;
  logic [31:0] quotient, remainder;
  logic        working, divEnd;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } expT;

  expT sb[$];
  int  nCompared = 0;
  int  nFail     = 0;

  m_divide dut (
    .clk              (clk),
    .rst              (rst),
    .i_divBegin_1     (divBegin),
    .i_divOperand1_32 (opA),
    .i_divOperand2_32 (opB),
    .i_divSigned_1    (sgn),
    .o_quotient_32    (quotient),
    .o_remainder_32   (remainder),
    .o_divWorking_1   (working),
    .o_divEnd_1       (divEnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one operation from a negedge in IDLE; optionally re-pulse begin
  // with different operands during cycle reBegin after the accept edge.
  task automatic doOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [31:0] q, input logic [31:0] r,
                      input int lat, input int reBegin);
    expT e;
    int  n;
    int  drops;
    bit  done;
    e.q = q; e.r = r; e.lat = lat;
    sb.push_back(e);
    opA = a; opB = b; sgn = s; divBegin = 1'b1;
    @(posedge clk);
    #1;
    divBegin = 1'b0;
    opA = $urandom; opB = $urandom;
    n = 0; drops = 0; done = 1'b0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (reBegin != 0 && n == reBegin) begin
        divBegin = 1'b1; opA = 32'd1000; opB = 32'd3;
      end else begin
        divBegin = 1'b0;
      end
      if (!working) drops++;
      if (divEnd) done = 1'b1;
    end
    divBegin = 1'b0;
    if (!done) check({tag, " timeout"}, 32'(n), 32'(lat));
    e = sb.pop_front();
    check({tag, " quotient"}, quotient, e.q);
    check({tag, " remainder"}, remainder, e.r);
    check({tag, " latency"}, 32'(n), 32'(e.lat));
    check({tag, " working drops"}, 32'(drops), 32'd0);
    @(negedge clk);
    check({tag, " post-done working/end"}, {30'd0, working, divEnd}, 32'd0);
  endtask

  task automatic randOp(input logic s);
    logic [31:0] a, b, q, r;
    logic signed [31:0] sa, sb2;
    a = $urandom;
    b = 32'($urandom_range(1, 1000));
    if (s && $urandom_range(0, 1) == 1) b = ~b + 32'd1;
    if (s) begin
      sa = a; sb2 = b;
      q = sa / sb2; r = sa % sb2;
    end else begin
      q = a / b; r = a % b;
    end
    doOp(s ? "rand signed" : "rand unsigned", a, b, s, q, r, 34, 0);
  endtask

  initial begin
    int ends;
    rst = 1'b1; divBegin = 1'b0; opA = '0; opB = '0; sgn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset working/end", {30'd0, working, divEnd}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    doOp("udiv 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34, 0);
    doOp("sdiv -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 0);
    doOp("sdiv 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 34, 0);
    doOp("div0 unsigned", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 2, 0);
    doOp("div0 signed", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 2, 0);
    doOp("div0 neg dividend", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 2, 0);
    doOp("overflow signed", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 2, 0);
    doOp("overflow unsigned", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 34, 0);
    doOp("udiv max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 34, 0);
    doOp("udiv small/large", 32'd5, 32'hFFFF_FFF0, 1'b0, 32'd0, 32'd5, 34, 0);
    for (int unsigned i = 0; i < 4; i++) randOp(1'b0);
    for (int unsigned i = 0; i < 4; i++) randOp(1'b1);
    doOp("rebegin ignored", 32'd12345, 32'd100, 1'b0, 32'd123, 32'd45, 34, 5);

    // Abort 10 cycles into CALC; outputs from the previous operation must clear.
    opA = 32'd100; opB = 32'd7; sgn = 1'b0; divBegin = 1'b1;
    @(posedge clk);
    #1;
    divBegin = 1'b0;
    repeat (10) @(negedge clk);
    check("pre-abort working", {31'd0, working}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort quotient", quotient, 32'd0);
    check("abort remainder", remainder, 32'd0);
    check("abort working/end", {30'd0, working, divEnd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ends = 0;
    repeat (40) begin
      @(negedge clk);
      if (divEnd) ends++;
    end
    check("abort no end pulse", 32'(ends), 32'd0);

    doOp("udiv 100/7 after abort", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

endmodule
